fabric_cfg_loader: RTL and testbench
====================================

# fabric_cfg_loader

Parametrised configuration loader for a multi-cluster tiny FPGA fabric. It replaces the single raw bit-serial programming chain with a byte-stream protocol that adds framing, per-cluster addressing, broadcast, CRC-8 checking and non-destructive readback. It sits between the chip I/O deserialiser and the configuration shift chains of `CLUSTERS` logic clusters, and holds the fabric in reset until every cluster holds a verified bitstream.

## Interface
- `CLUSTERS`, 4: number of logic clusters and chains, 1..127.
- `CHAIN_BITS`, 256: config bits per cluster chain; multiple of 8.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: input byte valid.
- `cfg_data` in 8: input byte.
- `cfg_ready` out 1: loader accepts byte when `cfg_valid & cfg_ready`.
- `chain_en` out CLUSTERS: per-chain shift enable, one cycle per bit.
- `chain_out` out 1: serial bit into the enabled chain(s).
- `chain_in` in CLUSTERS: serial tail bit of each chain.
- `rb_valid` out 1: readback byte valid.
- `rb_data` out 8: readback byte.
- `rb_ready` in 1: readback byte consumed when `rb_valid & rb_ready`.
- `fabric_rst_n` out 1: fabric reset, active-low.
- `done` out 1: all clusters configured.
- `err` out 1: sticky protocol/CRC error.

## Operation
- Frame: SYNC `0xA5`, CMD, then payload. CMD[7]=0 write, 1 readback; CMD[6:0]=cluster index, `0x7F` = broadcast (write only).
- Write payload: `CHAIN_BITS/8` data bytes, then one CRC byte. The CRC is CRC-8, poly `0x07`, init `0x00`, MSB-first, computed over CMD and the data bytes.
- States:
  - IDLE: ready; discards any byte ≠ `0xA5`. On SYNC: clear `err`, go to CMD.
  - CMD: ready; latch index/op, seed CRC.
    - Index ≥ CLUSTERS and ≠ `0x7F` → ERR.
    - Broadcast readback → ERR.
    - Otherwise → LOAD (write) or RB_SHIFT (read).
  - LOAD: ready; accept a byte, update CRC, → SHIFT.
  - SHIFT: not ready. Runs 8 cycles, LSB first: `chain_out`=bit, `chain_en`=one-hot(index) or all-ones for broadcast. Then → LOAD, or → CHK after the last data byte.
  - CHK: ready; compare the received byte with the CRC.
    - Match: set `configured[index]`, or all bits for broadcast.
    - Mismatch: clear those bits and set `err`.
    - Either way → IDLE.
  - RB_SHIFT: not ready. Runs 8 cycles: `chain_en[index]`=1, `chain_out=chain_in[index]` (recirculate, contents preserved). The tail bit shifts into `rb_data` LSB-first: the first bit captured lands in bit 0. Then → RB_OUT.
  - RB_OUT: `rb_valid`=1 holding `rb_data` until `rb_ready`. Then → RB_SHIFT, or → IDLE after `CHAIN_BITS/8` bytes. Readback never changes `configured`.
  - ERR: set `err`, `configured` unchanged, → IDLE next cycle.
- `done` = `&configured`, registered.
- `fabric_rst_n` = `done` and state==IDLE, registered. It drops during any later write frame and rises after a successful CHK.
- Byte and bit counters are sized `$clog2` of their ranges.
- A write of N bytes ends with chain bit 0 holding the last bit shifted.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - all outputs 0;
  - state IDLE, `configured`=0, `err`=0.
  - `cfg_ready` rises on the first edge after reset release.
- Reset mid-frame: abort immediately and clear `configured`. Chains are left partially shifted and count as invalid.
- A byte is accepted in LOAD at edge t. `chain_en` is active on edges t+1..t+8. `cfg_ready` returns at t+9 (LOAD) or t+9 (CHK).
- Write frame minimum duration: 2 + 9·(CHAIN_BITS/8) + 1 cycles.
- `done` and `fabric_rst_n` go high 1 cycle after the CHK accept edge.
- Readback: `rb_valid` rises 8 cycles after leaving CMD or after the previous `rb_ready` handshake. `rb_data` is stable while `rb_valid`.
- `cfg_valid` is ignored outside ready states. No byte is lost: ready is low.
- `err` is sticky until the next SYNC is accepted.

## Structure
- Package `fabric_cfg_pkg`:
  - `SYNC_BYTE`, `BCAST_IDX`, `CRC_POLY`;
  - CMD field positions;
  - state enum `cfg_state_t`.
- Sub-module `cfg_crc8`: combinational byte-wide CRC-8 next-state (crc_in, data → crc_out).
- The loader FSM, counters, `configured` register and readback shift register live in `fabric_cfg_loader`. Target is ~250 lines.

## Test plan
- Reset release → `cfg_ready`=1 next cycle; `done`=0, `fabric_rst_n`=0, `chain_en`=0.
- Broadcast write with CLUSTERS=4, CHAIN_BITS=16, payload `0x3C,0x81` and correct CRC:
  - `chain_en`=`4'hF` for 16 cycles;
  - bit sequence 0,0,1,1,1,1,0,0,1,0,0,0,0,0,0,1;
  - then `done`=1 and `fabric_rst_n`=1.
- Write to cluster 2 with a bad CRC after full configuration → `err`=1, `done`=0, `fabric_rst_n`=0. A subsequent good write to cluster 2 → `err` clears at SYNC, `done`=1.
- Readback of cluster 1 loaded with `0x3C,0x81` → `rb_data` `0x3C` then `0x81`. Cluster 1 contents are unchanged: a second readback gives identical bytes.
- CMD `0x05` with CLUSTERS=4 → ERR. The next bytes are discarded until `0xA5`, and `configured` is unchanged. Broadcast readback (`0xFF`) → ERR likewise.
- Backpressure: hold `rb_ready`=0 for 10 cycles → `rb_valid` and `rb_data` stay stable and `chain_en`=0. Assert `rst_n`=0 mid-SHIFT → all outputs 0 on the next edge.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared constants, command field positions and loader state encoding.
// No logic, no latency.
// Imported by every fabric configuration loader file.
package fabric_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [6:0] BCAST_IDX = 7'h7F;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  // CMD byte layout: bit 7 selects readback, bits 6:0 select the cluster
  localparam int CMD_OP_BIT  = 7;
  localparam int CMD_IDX_MSB = 6;
  localparam int CMD_IDX_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LOAD,
    ST_SHIFT,
    ST_CHK,
    ST_RB_SHIFT,
    ST_RB_OUT,
    ST_ERR
  } cfg_state_t;

endpackage

// File: rtl/fabric_cfg_loader_if.sv
// Byte-stream, chain and readback signals of the configuration loader.
// No latency (wires only).
// cfg_valid/cfg_ready and rb_valid/rb_ready carry the two handshakes.
interface fabric_cfg_if #(
  parameter int CLUSTERS = 4
) ();
  logic                cfg_valid;
  logic [7:0]          cfg_data;
  logic                cfg_ready;
  logic [CLUSTERS-1:0] chain_en;
  logic                chain_out;
  logic [CLUSTERS-1:0] chain_in;
  logic                rb_valid;
  logic [7:0]          rb_data;
  logic                rb_ready;
  logic                fabric_rst_n;
  logic                done;
  logic                err;

  // loader side
  modport slave (
    input  cfg_valid, cfg_data, chain_in, rb_ready,
    output cfg_ready, chain_en, chain_out, rb_valid, rb_data,
           fabric_rst_n, done, err
  );

  // byte source / chain / readback consumer side
  modport master (
    output cfg_valid, cfg_data, chain_in, rb_ready,
    input  cfg_ready, chain_en, chain_out, rb_valid, rb_data,
           fabric_rst_n, done, err
  );
endinterface

// File: rtl/cfg_crc8.sv
// Byte-wide CRC-8 (poly 0x07, MSB-first) next-state function.
// Combinational, zero latency.
// No handshake; caller decides when to register the result.
module cfg_crc8
  import fabric_cfg_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);
  logic [7:0] w_c;

  // fold the data byte in one bit at a time, MSB first
  always_comb begin
    w_c = i_crc;
    for (int i = 7; i >= 0; i--) begin
      w_c = (w_c[7] ^ i_data[i]) ? ((w_c << 1) ^ CRC_POLY) : (w_c << 1);
    end
  end

  assign o_crc = w_c;
endmodule

// File: rtl/fabric_cfg_loader.sv
// Framed byte-stream loader for CLUSTERS config chains with CRC and readback.
// Each write byte costs 1 accept + 8 shift cycles; readback byte ready 8 cycles after request.
// cfg_ready drops while shifting; readback holds rb_valid/rb_data until rb_ready.
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
#(
  parameter int CLUSTERS   = 4,
  parameter int CHAIN_BITS = 256
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fabric_cfg_if.slave   io_bus
);
  localparam int NBYTES = CHAIN_BITS / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IDX_W  = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  cfg_state_t          r_state, w_next;
  logic                r_live;
  logic [IDX_W-1:0]    r_sel;
  logic                r_bcast;
  logic [7:0]          r_crc;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit;
  logic [BYTE_W-1:0]   r_byte;
  logic [7:0]          r_rb;
  logic [CLUSTERS-1:0] r_configured;
  logic                r_done, r_frst_n, r_err;

  logic                w_ready, w_accept, w_chain_out, w_rb_valid, w_cmd_rd, w_idx_bad;
  logic [CLUSTERS-1:0] w_mask, w_chain_en;
  logic [6:0]          w_cmd_idx;
  logic [7:0]          w_crc_in, w_crc_out;

  assign w_cmd_idx = io_bus.cfg_data[CMD_IDX_MSB:CMD_IDX_LSB];
  assign w_cmd_rd  = io_bus.cfg_data[CMD_OP_BIT];
  assign w_idx_bad = (w_cmd_idx != BCAST_IDX) && (32'(w_cmd_idx) >= 32'(CLUSTERS));
  assign w_accept  = io_bus.cfg_valid & w_ready;
  // the CMD byte is the first byte covered by the CRC, so it starts from zero
  assign w_crc_in  = (r_state == ST_CMD) ? 8'h00 : r_crc;

  cfg_crc8 u_crc (
    .i_crc  (w_crc_in),
    .i_data (io_bus.cfg_data),
    .o_crc  (w_crc_out)
  );

  // chains addressed by the current frame: one-hot or all for broadcast
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < CLUSTERS; i++) begin
      w_mask[i] = r_bcast | (r_sel == IDX_W'(i));
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // next-state and handshake/chain outputs
  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_chain_en  = '0;
    w_chain_out = 1'b0;
    w_rb_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = r_live;
        if (r_live && io_bus.cfg_valid && io_bus.cfg_data == SYNC_BYTE) w_next = ST_CMD;
      end
      ST_CMD: begin
        w_ready = 1'b1;
        if (io_bus.cfg_valid) begin
          if (w_idx_bad || (w_cmd_rd && w_cmd_idx == BCAST_IDX)) w_next = ST_ERR;
          else if (w_cmd_rd)                                      w_next = ST_RB_SHIFT;
          else                                                    w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (io_bus.cfg_valid) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_chain_en  = w_mask;
        w_chain_out = r_shift[0];
        if (r_bit == 3'd7) w_next = (r_byte == LAST_BYTE) ? ST_CHK : ST_LOAD;
      end
      ST_CHK: begin
        w_ready = 1'b1;
        if (io_bus.cfg_valid) w_next = ST_IDLE;
      end
      ST_RB_SHIFT: begin
        // recirculate the tail so the chain ends where it started
        w_chain_en  = w_mask;
        w_chain_out = io_bus.chain_in[r_sel];
        if (r_bit == 3'd7) w_next = ST_RB_OUT;
      end
      ST_RB_OUT: begin
        w_rb_valid = 1'b1;
        if (io_bus.rb_ready) w_next = (r_byte == LAST_BYTE) ? ST_IDLE : ST_RB_SHIFT;
      end
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // frame datapath: counters, CRC, shift registers, status flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_live       <= 1'b0;
      r_sel        <= '0;
      r_bcast      <= 1'b0;
      r_crc        <= '0;
      r_shift      <= '0;
      r_bit        <= '0;
      r_byte       <= '0;
      r_rb         <= '0;
      r_configured <= '0;
      r_done       <= 1'b0;
      r_frst_n     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_accept && io_bus.cfg_data == SYNC_BYTE) r_err <= 1'b0;
        ST_CMD: if (w_accept) begin
          r_sel   <= w_cmd_idx[IDX_W-1:0];
          r_bcast <= (w_cmd_idx == BCAST_IDX);
          r_crc   <= w_crc_out;
          r_bit   <= '0;
          r_byte  <= '0;
        end
        ST_LOAD: if (w_accept) begin
          r_crc   <= w_crc_out;
          r_shift <= io_bus.cfg_data;
          r_bit   <= '0;
        end
        ST_SHIFT: begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_byte <= r_byte + BYTE_W'(1);
        end
        ST_CHK: if (w_accept) begin
          if (io_bus.cfg_data == r_crc) begin
            r_configured <= r_configured | w_mask;
          end else begin
            r_configured <= r_configured & ~w_mask;
            r_err        <= 1'b1;
          end
        end
        ST_RB_SHIFT: begin
          // first captured tail bit ends up in bit 0 after eight shifts
          r_rb  <= {io_bus.chain_in[r_sel], r_rb[7:1]};
          r_bit <= r_bit + 3'd1;
        end
        ST_RB_OUT: if (io_bus.rb_ready) r_byte <= r_byte + BYTE_W'(1);
        ST_ERR:    r_err <= 1'b1;
        default: ;
      endcase
      r_done   <= &r_configured;
      r_frst_n <= (&r_configured) && (r_state == ST_IDLE);
    end
  end

  assign io_bus.cfg_ready    = w_ready;
  assign io_bus.chain_en     = w_chain_en;
  assign io_bus.chain_out    = w_chain_out;
  assign io_bus.rb_valid     = w_rb_valid;
  assign io_bus.rb_data      = r_rb;
  assign io_bus.fabric_rst_n = r_frst_n;
  assign io_bus.done         = r_done;
  assign io_bus.err          = r_err;
endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed bench for fabric_cfg_loader with a behavioural chain model.
// Expected chain bits and readback bytes are queued when stimulus is driven.
// Exercises framing, CRC pass/fail, readback backpressure, bad CMDs and reset.
module tb_fabric_cfg_loader;
  localparam int NCL = 4;
  localparam int NCB = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic       exp_bits[$];
  logic [7:0] rb_q[$];
  logic [NCB-1:0] chains [NCL];

  fabric_cfg_if #(.CLUSTERS(NCL)) u_if ();

  fabric_cfg_loader #(.CLUSTERS(NCL), .CHAIN_BITS(NCB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  // fabric chains: head takes chain_out, tail (MSB) feeds chain_in
  always @(posedge clk) begin
    for (int i = 0; i < NCL; i++)
      if (u_if.chain_en[i]) chains[i] <= {chains[i][NCB-2:0], u_if.chain_out};
  end

  always_comb begin
    for (int i = 0; i < NCL; i++) u_if.chain_in[i] = chains[i][NCB-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    u_if.cfg_valid = 1'b1;
    u_if.cfg_data  = b;
    while (!u_if.cfg_ready && n < 40) begin
      tick();
      n++;
    end
    if (!u_if.cfg_ready) check("cfg_ready_timeout", 32'(u_if.cfg_ready), 32'd1);
    tick();
    u_if.cfg_valid = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] b0, input logic [7:0] b1,
                          input bit bad, input logic [NCL-1:0] mask);
    logic [7:0] crc, b, bit_exp;
    crc = crc8(8'h00, cmd);
    send_byte(8'hA5);
    check("err_clear_at_sync", 32'(u_if.err), 32'd0);
    send_byte(cmd);
    for (int k = 0; k < 2; k++) begin
      b   = (k == 0) ? b0 : b1;
      crc = crc8(crc, b);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      send_byte(b);
      for (int i = 0; i < 8; i++) begin
        bit_exp = 8'(exp_bits.pop_front());
        check("chain_en_shift", 32'(u_if.chain_en), 32'(mask));
        check("chain_out_bit", 32'(u_if.chain_out), 32'(bit_exp));
        check("cfg_ready_shift", 32'(u_if.cfg_ready), 32'd0);
        tick();
      end
      check("chain_en_after_byte", 32'(u_if.chain_en), 32'd0);
    end
    send_byte(bad ? ~crc : crc);
    check("chain_en_after_crc", 32'(u_if.chain_en), 32'd0);
  endtask

  task automatic rd_frame(input logic [7:0] cmd, input logic [7:0] e0, input logic [7:0] e1,
                          input bit hold);
    int n;
    rb_q.push_back(e0);
    rb_q.push_back(e1);
    send_byte(8'hA5);
    send_byte(cmd);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!u_if.rb_valid && n < 20) begin
        tick();
        n++;
      end
      check("rb_latency", 32'(n), 32'd8);
      if (hold && k == 0) begin
        for (int c = 0; c < 10; c++) begin
          check("rb_hold_valid", 32'(u_if.rb_valid), 32'd1);
          check("rb_hold_data", 32'(u_if.rb_data), 32'(rb_q[0]));
          check("rb_hold_chain_en", 32'(u_if.chain_en), 32'd0);
          tick();
        end
      end
      check("rb_data", 32'(u_if.rb_data), 32'(rb_q.pop_front()));
      u_if.rb_ready = 1'b1;
      tick();
      u_if.rb_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    u_if.cfg_valid = 1'b0;
    u_if.cfg_data  = 8'h00;
    u_if.rb_ready  = 1'b0;
    repeat (3) tick();
    check("rst_cfg_ready", 32'(u_if.cfg_ready), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check("rst_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd0);
    check("rst_chain_en", 32'(u_if.chain_en), 32'd0);
    check("rst_err", 32'(u_if.err), 32'd0);
    check("rst_rb_valid", 32'(u_if.rb_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_cfg_ready", 32'(u_if.cfg_ready), 32'd1);
    check("rel_done", 32'(u_if.done), 32'd0);
    check("rel_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd0);
    check("rel_chain_en", 32'(u_if.chain_en), 32'd0);

    // broadcast write configures every cluster
    wr_frame(8'h7F, 8'h3C, 8'h81, 1'b0, 4'hF);
    check("bcast_done_same_edge", 32'(u_if.done), 32'd0);
    tick();
    check("bcast_done", 32'(u_if.done), 32'd1);
    check("bcast_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd1);
    check("bcast_err", 32'(u_if.err), 32'd0);

    // readback of cluster 1 twice, first with backpressure
    rd_frame(8'h81, 8'h3C, 8'h81, 1'b1);
    tick();
    check("rb1_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd1);
    rd_frame(8'h81, 8'h3C, 8'h81, 1'b0);
    tick();
    check("rb2_done", 32'(u_if.done), 32'd1);

    // bad CRC on cluster 2, then a good rewrite
    wr_frame(8'h02, 8'h55, 8'hAA, 1'b1, 4'b0100);
    tick();
    check("badcrc_err", 32'(u_if.err), 32'd1);
    check("badcrc_done", 32'(u_if.done), 32'd0);
    check("badcrc_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd0);
    wr_frame(8'h02, 8'h55, 8'hAA, 1'b0, 4'b0100);
    tick();
    check("goodcrc_done", 32'(u_if.done), 32'd1);
    check("goodcrc_err", 32'(u_if.err), 32'd0);
    check("goodcrc_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd1);
    rd_frame(8'h82, 8'h55, 8'hAA, 1'b0);

    // out-of-range cluster index, then trailing junk is discarded
    send_byte(8'hA5);
    send_byte(8'h05);
    tick();
    check("badidx_err", 32'(u_if.err), 32'd1);
    check("badidx_done", 32'(u_if.done), 32'd1);
    send_byte(8'h00);
    send_byte(8'h81);
    send_byte(8'h7F);
    for (int c = 0; c < 12; c++) begin
      check("junk_chain_en", 32'(u_if.chain_en), 32'd0);
      check("junk_rb_valid", 32'(u_if.rb_valid), 32'd0);
      tick();
    end
    check("junk_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd1);

    // broadcast readback is rejected
    send_byte(8'hA5);
    check("bcrd_err_clear", 32'(u_if.err), 32'd0);
    send_byte(8'hFF);
    tick();
    check("bcrd_err", 32'(u_if.err), 32'd1);
    check("bcrd_done", 32'(u_if.done), 32'd1);
    check("bcrd_chain_en", 32'(u_if.chain_en), 32'd0);

    // reset in the middle of a shift
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h5A);
    tick();
    tick();
    check("midshift_chain_en", 32'(u_if.chain_en), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_cfg_ready", 32'(u_if.cfg_ready), 32'd0);
    check("midrst_chain_en", 32'(u_if.chain_en), 32'd0);
    check("midrst_chain_out", 32'(u_if.chain_out), 32'd0);
    check("midrst_rb_valid", 32'(u_if.rb_valid), 32'd0);
    check("midrst_rb_data", 32'(u_if.rb_data), 32'd0);
    check("midrst_fabric_rst_n", 32'(u_if.fabric_rst_n), 32'd0);
    check("midrst_done", 32'(u_if.done), 32'd0);
    check("midrst_err", 32'(u_if.err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cfg_ready", 32'(u_if.cfg_ready), 32'd1);
    tick();
    check("post_rst_done", 32'(u_if.done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
